mif_rd_resp: RTL and testbench

- Memory-interface side of the IBC read path. Responds to IBC read-address requests by popping the address FIFO and issuing reads to the backing RAM port.
- Returns read data in order on the data/data_en bus shared by all ports.
- Provides no backpressure toward IBC data. Flow control is internal: a credit check ensures every accepted read has a slot in the response FIFO.

---
 rtl/mif_rd_resp.sv | 152 +++++++++++++++
 tb/tb_mif_rd_resp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mif_rd_resp.sv
// Memory-interface read responder: pops IBC read addresses, issues RAM reads, returns data in order.
// Optional statistics outputs are enabled by defining MIF_RD_RESP_STATS_EN.
module mif_rd_resp #(
    parameter int unsigned rAddrWidth = 28,
    parameter int unsigned rDataWidth = 64,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                  clk_bus,
    input  logic                  rst_bus,
    input  logic [rAddrWidth-1:0] ibc2mem_r_addr,
    input  logic                  ibc2mem_r_vld,
    output logic                  mem2ibc_en,
    output logic [rDataWidth-1:0] mem2ibc_data,
    output logic                  mem2ibc_data_en,
    output logic                  ram_req,
    output logic [rAddrWidth-1:0] ram_addr,
    input  logic                  ram_gnt,
    input  logic                  ram_rvld,
    input  logic [rDataWidth-1:0] ram_rdata,
    output logic                  err_unexp
`ifdef MIF_RD_RESP_STATS_EN
    ,
    output logic [31:0]                   stat_rd_issued,
    output logic [31:0]                   stat_rd_done,
    output logic [$clog2(RESP_DEPTH):0]   stat_max_out
`endif
);

    localparam int unsigned PW   = $clog2(RESP_DEPTH);
    localparam int unsigned CNTW = PW + 1;
    localparam int unsigned CW   = PW + 2;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

    state_t                  state;
    logic [CNTW-1:0]         outstanding;
    logic [CNTW-1:0]         wr_ptr;
    logic [CNTW-1:0]         rd_ptr;
    logic [rDataWidth-1:0]   fifo_mem [RESP_DEPTH];

    logic [CNTW-1:0]         fifo_cnt_c;
    logic [CW-1:0]           credits_used_c;
    logic                    credit_ok_c;
    logic                    gnt_acc_c;
    logic                    rvld_ok_c;
    logic                    fifo_pop_c;

    // A response is legal if a read is in flight or is being granted this same cycle.
    assign gnt_acc_c      = ram_req & ram_gnt;
    assign rvld_ok_c      = ram_rvld & ((outstanding != '0) | gnt_acc_c);
    assign fifo_cnt_c     = wr_ptr - rd_ptr;
    assign fifo_pop_c     = (fifo_cnt_c != '0);
    assign credits_used_c = CW'(outstanding) + CW'(fifo_cnt_c) + CW'(state == ST_REQ);
    assign credit_ok_c    = (credits_used_c < CW'(RESP_DEPTH));

    // Request FSM: capture address on the pop edge, hold the request until granted.
    always_ff @(posedge clk_bus or negedge rst_bus) begin
        if (!rst_bus) begin
            state      <= ST_IDLE;
            mem2ibc_en <= 1'b0;
            ram_req    <= 1'b0;
            ram_addr   <= '0;
        end else begin
            mem2ibc_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ibc2mem_r_vld && credit_ok_c) begin
                        mem2ibc_en <= 1'b1;
                        ram_addr   <= ibc2mem_r_addr;
                        ram_req    <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ram_gnt) begin
                        ram_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    ram_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Outstanding read count and sticky unexpected-response flag.
    always_ff @(posedge clk_bus or negedge rst_bus) begin
        if (!rst_bus) begin
            outstanding <= '0;
            err_unexp   <= 1'b0;
        end else begin
            case ({gnt_acc_c, rvld_ok_c})
                2'b10:   outstanding <= outstanding + CNTW'(1);
                2'b01:   outstanding <= outstanding - CNTW'(1);
                default: outstanding <= outstanding;
            endcase
            err_unexp <= err_unexp | (ram_rvld & ~rvld_ok_c);
        end
    end

    // Response FIFO storage needs no reset; pointers define validity.
    always_ff @(posedge clk_bus) begin
        if (rvld_ok_c) begin
            fifo_mem[wr_ptr[PW-1:0]] <= ram_rdata;
        end
    end

    always_ff @(posedge clk_bus or negedge rst_bus) begin
        if (!rst_bus) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            mem2ibc_data    <= '0;
            mem2ibc_data_en <= 1'b0;
        end else begin
            if (rvld_ok_c) begin
                wr_ptr <= wr_ptr + CNTW'(1);
            end
            mem2ibc_data_en <= fifo_pop_c;
            if (fifo_pop_c) begin
                mem2ibc_data <= fifo_mem[rd_ptr[PW-1:0]];
                rd_ptr       <= rd_ptr + CNTW'(1);
            end
        end
    end

`ifdef MIF_RD_RESP_STATS_EN
    // Free-running statistics; counters wrap naturally at 32 bits.
    always_ff @(posedge clk_bus or negedge rst_bus) begin
        if (!rst_bus) begin
            stat_rd_issued <= '0;
            stat_rd_done   <= '0;
            stat_max_out   <= '0;
        end else begin
            if (gnt_acc_c) begin
                stat_rd_issued <= stat_rd_issued + 32'd1;
            end
            if (mem2ibc_data_en) begin
                stat_rd_done <= stat_rd_done + 32'd1;
            end
            if (credits_used_c > CW'(stat_max_out)) begin
                stat_max_out <= credits_used_c[PW:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_mif_rd_resp.sv
// Directed bench for mif_rd_resp: single read, stall, credit limit, ordering, gnt+rvld overlap, errors/reset.
module tb_mif_rd_resp;

    logic        clk_bus = 1'b0;
    logic        rst_bus = 1'b0;
    logic [27:0] ibc2mem_r_addr = '0;
    logic        ibc2mem_r_vld = 1'b0;
    logic        mem2ibc_en;
    logic [63:0] mem2ibc_data;
    logic        mem2ibc_data_en;
    logic        ram_req;
    logic [27:0] ram_addr;
    logic        ram_gnt = 1'b0;
    logic        ram_rvld = 1'b0;
    logic [63:0] ram_rdata = '0;
    logic        err_unexp;

    int          n_cmp = 0;
    int          n_err = 0;
    int          pop_cnt = 0;
    int          gnt_cnt = 0;
    logic [27:0] aq[$];
    logic [63:0] dq[$];

    mif_rd_resp dut (
        .clk_bus         (clk_bus),
        .rst_bus         (rst_bus),
        .ibc2mem_r_addr  (ibc2mem_r_addr),
        .ibc2mem_r_vld   (ibc2mem_r_vld),
        .mem2ibc_en      (mem2ibc_en),
        .mem2ibc_data    (mem2ibc_data),
        .mem2ibc_data_en (mem2ibc_data_en),
        .ram_req         (ram_req),
        .ram_addr        (ram_addr),
        .ram_gnt         (ram_gnt),
        .ram_rvld        (ram_rvld),
        .ram_rdata       (ram_rdata),
        .err_unexp       (err_unexp)
    );

    always #5 clk_bus = ~clk_bus;

    // IBC address FIFO model: head advances on the pop pulse.
    always @(negedge clk_bus) begin
        if (mem2ibc_en && aq.size() != 0) void'(aq.pop_front());
        ibc2mem_r_vld  = (aq.size() != 0);
        ibc2mem_r_addr = (aq.size() != 0) ? aq[0] : 28'h0;
    end

    // Event monitor: pops, accepted grants, returned words.
    always @(posedge clk_bus) begin
        if (mem2ibc_en) pop_cnt++;
        if (ram_req && ram_gnt) gnt_cnt++;
        if (mem2ibc_data_en) dq.push_back(mem2ibc_data);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_bus);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},     64'(mem2ibc_en), 64'd0);
        check({tag, "_de"},     64'(mem2ibc_data_en), 64'd0);
        check({tag, "_data"},   mem2ibc_data, 64'd0);
        check({tag, "_req"},    64'(ram_req), 64'd0);
        check({tag, "_addr"},   64'(ram_addr), 64'd0);
        check({tag, "_err"},    64'(err_unexp), 64'd0);
    endtask

    task automatic do_reset();
        rst_bus   = 1'b0;
        aq.delete();
        ram_gnt   = 1'b0;
        ram_rvld  = 1'b0;
        ram_rdata = '0;
        tick(2);
        rst_bus = 1'b1;
        pop_cnt = 0;
        gnt_cnt = 0;
        dq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(2);
        check_all_zero("rst");

        // Single read, immediate grant, response three cycles after grant
        do_reset();
        aq.push_back(28'h0000123);
        tick(1);
        check("t1_en",   64'(mem2ibc_en), 64'd1);
        check("t1_req",  64'(ram_req), 64'd1);
        check("t1_addr", 64'(ram_addr), 64'h123);
        ram_gnt = 1'b1;
        tick(1);
        ram_gnt = 1'b0;
        check("t1_req_drop", 64'(ram_req), 64'd0);
        check("t1_en_drop",  64'(mem2ibc_en), 64'd0);
        tick(2);
        ram_rvld  = 1'b1;
        ram_rdata = 64'hDEADBEEF_CAFEF00D;
        tick(1);
        ram_rvld = 1'b0;
        check("t1_de_early", 64'(mem2ibc_data_en), 64'd0);
        tick(1);
        check("t1_de",   64'(mem2ibc_data_en), 64'd1);
        check("t1_data", mem2ibc_data, 64'hDEADBEEF_CAFEF00D);
        tick(1);
        check("t1_de_off",  64'(mem2ibc_data_en), 64'd0);
        check("t1_hold",    mem2ibc_data, 64'hDEADBEEF_CAFEF00D);
        check("t1_pops",    64'(pop_cnt), 64'd1);
        check("t1_gnts",    64'(gnt_cnt), 64'd1);

        // Grant withheld for 10 cycles
        do_reset();
        aq.push_back(28'h0ABCDEF);
        aq.push_back(28'h0000456);
        tick(1);
        for (int i = 0; i < 10; i++) begin
            check("t2_req_held",  64'(ram_req), 64'd1);
            check("t2_addr_held", 64'(ram_addr), 64'h0ABCDEF);
            tick(1);
        end
        check("t2_pops_stall", 64'(pop_cnt), 64'd1);
        ram_gnt = 1'b1;
        tick(1);
        ram_gnt = 1'b0;
        tick(1);
        check("t2_gnts",  64'(gnt_cnt), 64'd1);
        check("t2_req2",  64'(ram_req), 64'd1);
        check("t2_addr2", 64'(ram_addr), 64'h456);
        tick(1);
        check("t2_pops2", 64'(pop_cnt), 64'd2);

        // Credit limit: 8 queued, no responses
        do_reset();
        for (int i = 0; i < 8; i++) aq.push_back(28'(28'h100 + i));
        ram_gnt = 1'b1;
        tick(30);
        check("t3_pops_lim", 64'(pop_cnt), 64'd4);
        check("t3_gnts_lim", 64'(gnt_cnt), 64'd4);
        check("t3_no_data",  64'(dq.size()), 64'd0);
        check("t3_req_idle", 64'(ram_req), 64'd0);
        ram_rvld  = 1'b1;
        ram_rdata = 64'h11;
        tick(1);
        ram_rvld = 1'b0;
        tick(1);
        check("t3_de",         64'(mem2ibc_data_en), 64'd1);
        check("t3_data",       mem2ibc_data, 64'h11);
        check("t3_pops_at_de", 64'(pop_cnt), 64'd4);
        tick(5);
        check("t3_pops5", 64'(pop_cnt), 64'd5);
        check("t3_gnts5", 64'(gnt_cnt), 64'd5);
        check("t3_addr5", 64'(ram_addr), 64'h104);
        tick(10);
        check("t3_pops_relim", 64'(pop_cnt), 64'd5);
        ram_gnt = 1'b0;

        // Ordering and throughput: four back-to-back responses
        do_reset();
        for (int i = 0; i < 4; i++) aq.push_back(28'(28'h200 + i));
        ram_gnt = 1'b1;
        tick(12);
        ram_gnt = 1'b0;
        check("t4_gnts", 64'(gnt_cnt), 64'd4);
        for (int i = 0; i < 4; i++) begin
            ram_rvld  = 1'b1;
            ram_rdata = 64'(i + 1);
            if (i == 1) check("t4_lat", 64'(mem2ibc_data_en), 64'd0);
            if (i >= 2) begin
                check("t4_de",   64'(mem2ibc_data_en), 64'd1);
                check("t4_data", mem2ibc_data, 64'(i - 1));
            end
            tick(1);
        end
        ram_rvld = 1'b0;
        check("t4_de3",   64'(mem2ibc_data_en), 64'd1);
        check("t4_data3", mem2ibc_data, 64'd3);
        tick(1);
        check("t4_de4",   64'(mem2ibc_data_en), 64'd1);
        check("t4_data4", mem2ibc_data, 64'd4);
        tick(1);
        check("t4_de_off", 64'(mem2ibc_data_en), 64'd0);
        check("t4_hold",   mem2ibc_data, 64'd4);
        check("t4_count",  64'(dq.size()), 64'd4);
        check("t4_err",    64'(err_unexp), 64'd0);

        // Grant and response in the same cycle
        do_reset();
        aq.push_back(28'h0000300);
        aq.push_back(28'h0000301);
        tick(1);
        ram_gnt = 1'b1;
        tick(2);
        check("t5_req_overlap", 64'(ram_req), 64'd1);
        ram_rvld  = 1'b1;
        ram_rdata = 64'hA5;
        tick(1);
        ram_rvld = 1'b0;
        ram_gnt  = 1'b0;
        tick(2);
        ram_rvld  = 1'b1;
        ram_rdata = 64'h5A;
        tick(1);
        ram_rvld = 1'b0;
        tick(4);
        check("t5_count", 64'(dq.size()), 64'd2);
        check("t5_gnts",  64'(gnt_cnt), 64'd2);
        check("t5_err",   64'(err_unexp), 64'd0);
        if (dq.size() == 2) begin
            check("t5_d0", dq[0], 64'hA5);
            check("t5_d1", dq[1], 64'h5A);
        end

        // Unexpected response, then reset mid-burst and a late response
        do_reset();
        ram_rvld  = 1'b1;
        ram_rdata = 64'h77;
        tick(1);
        ram_rvld = 1'b0;
        check("t6_err_set", 64'(err_unexp), 64'd1);
        tick(3);
        check("t6_err_held", 64'(err_unexp), 64'd1);
        check("t6_no_data",  64'(dq.size()), 64'd0);
        for (int i = 0; i < 3; i++) aq.push_back(28'(28'h400 + i));
        ram_gnt = 1'b1;
        tick(4);
        #2;
        rst_bus = 1'b0;
        aq.delete();
        ram_gnt = 1'b0;
        #1;
        check_all_zero("t6_async");
        tick(2);
        rst_bus = 1'b1;
        dq.delete();
        tick(2);
        ram_rvld  = 1'b1;
        ram_rdata = 64'h99;
        tick(1);
        ram_rvld = 1'b0;
        check("t6_late_err", 64'(err_unexp), 64'd1);
        tick(3);
        check("t6_late_nodata", 64'(dq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
